// File: rtl/rotary_quad_decoder.sv
// Quadrature encoder front-end: 2-flop sync, per-channel debounce, detent decode; optional ROT_POS_EN adds a signed detent counter `pos`.
// Latency: step_pulse 2 cycles and rotation_event 3 cycles after the filtered pins reach 11; no backpressure (free-running strobes).
module rotary_quad_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned POS_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rot_a,
  input  logic             rot_b,
  output logic             rotation_event,
  output logic             rotation_direction,
`ifdef ROT_POS_EN
  output logic [POS_W-1:0] pos,
`endif
  output logic             step_pulse
);

  localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 || POS_W < 1) begin : g_bad_param
    $error("rotary_quad_decoder: DEBOUNCE_CYCLES must be 1..65535 and POS_W >= 1");
  end

  // Channel vectors: bit 1 = A, bit 0 = B.
  logic [1:0]  sync1_q, sync1_d;
  logic [1:0]  sync2_q, sync2_d;
  logic [1:0]  filt_q, filt_d;
  logic [15:0] cnt_q [2];
  logic [15:0] cnt_d [2];

  logic q1_q, q1_d;
  logic q1_dly_q, q1_dly_d;
  logic q2_q, q2_d;
  logic event_q, event_d;
  logic dir_q, dir_d;
  logic step_q, step_d;

  logic a_f, b_f;
  assign a_f = filt_q[1];
  assign b_f = filt_q[0];

  always_comb begin
    sync1_d = {rot_a, rot_b};
    sync2_d = sync1_q;
    filt_d  = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == DEB_LAST) filt_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // q1 only moves on 11/00, so one step per 00->11 traversal; q2 remembers the last 01/10 seen.
  always_comb begin
    q1_d = q1_q;
    if (a_f && b_f)        q1_d = 1'b1;
    else if (!a_f && !b_f) q1_d = 1'b0;

    q2_d = q2_q;
    if (!a_f && b_f)      q2_d = 1'b1;
    else if (a_f && !b_f) q2_d = 1'b0;

    q1_dly_d = q1_q;
    step_d   = q1_q & ~q1_dly_q;
    dir_d    = step_d ? q2_q : dir_q;
    event_d  = q1_dly_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      filt_q   <= 2'b11;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      q1_q     <= 1'b1;
      q1_dly_q <= 1'b1;
      q2_q     <= 1'b0;
      event_q  <= 1'b1;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      filt_q   <= filt_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      q1_q     <= q1_d;
      q1_dly_q <= q1_dly_d;
      q2_q     <= q2_d;
      event_q  <= event_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
    end
  end

  assign rotation_event     = event_q;
  assign rotation_direction = dir_q;
  assign step_pulse         = step_q;

`ifdef ROT_POS_EN
  logic [POS_W-1:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (step_q) pos_d = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pos_q <= '0;
    else        pos_q <= pos_d;
  end

  assign pos = pos_q;
`endif

endmodule
